lpm_tbl_access_ctrl: RTL and testbench

LPM_TBL_ACCESS_CTRL -- requirements
Module: lpm_tbl_access_ctrl

---
 rtl/lpm_tbl_pkg.sv | 38 +++
 rtl/lpm_tbl_access_ctrl_ack_timer.sv | 36 +++
 rtl/lpm_tbl_access_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_lpm_tbl_access_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpm_tbl_pkg.sv
// Shared types and constants for the LPM table access controller and lookup block.
package lpm_tbl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4
    } tbl_state_e;

    localparam int unsigned REG_ADDR_W = 6;

    localparam logic [REG_ADDR_W-1:0] OFF_CMD    = 6'h00;
    localparam logic [REG_ADDR_W-1:0] OFF_STATUS = 6'h04;
    localparam logic [REG_ADDR_W-1:0] OFF_WDATA0 = 6'h10;
    localparam logic [REG_ADDR_W-1:0] OFF_RDATA0 = 6'h20;

    localparam int unsigned CMD_WR_BIT  = 0;
    localparam int unsigned CMD_RD_BIT  = 1;
    localparam int unsigned CMD_IDX_LSB = 8;

    // Entry layout, low word first: {queue, next_hop, mask, ip}
    localparam int unsigned ENTRY_FIELDS = 4;
    typedef enum logic [1:0] {
        FLD_IP    = 2'd0,
        FLD_MASK  = 2'd1,
        FLD_NHOP  = 2'd2,
        FLD_QUEUE = 2'd3
    } tbl_fld_e;

    // True when addr is a word-aligned offset inside the 4-word bank starting at base.
    function automatic logic in_bank(input logic [REG_ADDR_W-1:0] addr,
                                     input logic [REG_ADDR_W-1:0] base);
        return (addr[5:4] == base[5:4]) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/lpm_tbl_access_ctrl_ack_timer.sv
// Loadable down-counter; expired_c flags the last cycle of the ack window.
module lpm_ack_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic expired_c
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(TIMEOUT - 1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/lpm_tbl_access_ctrl.sv
// Register-driven single-entry read/write engine for the LPM table.
// Optional write readback-verify is enabled by defining LPM_TBL_VERIFY_EN.
module lpm_tbl_access_ctrl
    import lpm_tbl_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned TBL_ADDR_WIDTH     = 5,
    parameter int unsigned ACK_TIMEOUT        = 16
) (
    input  logic                                       AXI_ACLK,
    input  logic                                       AXI_RESETN,
    input  logic                                       reg_wr_en,
    input  logic                                       reg_rd_en,
    input  logic [REG_ADDR_W-1:0]                      reg_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]              reg_wdata,
    output logic [C_S_AXI_DATA_WIDTH-1:0]              reg_rdata,
    output logic                                       tbl_wr_req,
    output logic                                       tbl_rd_req,
    output logic [TBL_ADDR_WIDTH-1:0]                  tbl_wr_addr,
    output logic [TBL_ADDR_WIDTH-1:0]                  tbl_rd_addr,
    output logic [ENTRY_FIELDS*C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
    input  logic [ENTRY_FIELDS*C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
    input  logic                                       tbl_wr_ack,
    input  logic                                       tbl_rd_ack
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned EW = ENTRY_FIELDS * DW;
    localparam int unsigned AW = TBL_ADDR_WIDTH;

    tbl_state_e                        state_q, state_d;
    logic [ENTRY_FIELDS-1:0][DW-1:0]   wdata_q, wdata_d;
    logic [ENTRY_FIELDS-1:0][DW-1:0]   rdata_q, rdata_d;
    logic [DW-1:0]                     reg_rdata_q, reg_rdata_d;
    logic                              wr_req_q, wr_req_d;
    logic                              rd_req_q, rd_req_d;
    logic [AW-1:0]                     wr_addr_q, wr_addr_d;
    logic [AW-1:0]                     rd_addr_q, rd_addr_d;
    logic [EW-1:0]                     wr_data_q, wr_data_d;
    logic                              done_q, done_d;
    logic                              timeout_q, timeout_d;

    logic          cmd_wr_c;
    logic          status_rd_c;
    logic          busy_c;
    logic          verify_err_c;
    logic          in_wait_c;
    logic          load_c;
    logic          expired_c;
    logic [AW-1:0] cmd_idx_c;
    logic [DW-1:0] status_c;

`ifdef LPM_TBL_VERIFY_EN
    logic verify_err_q, verify_err_d;
    logic vfy_q, vfy_d;
    assign verify_err_c = verify_err_q;
`else
    assign verify_err_c = 1'b0;
`endif

    assign cmd_wr_c    = reg_wr_en && (reg_addr == OFF_CMD);
    assign status_rd_c = reg_rd_en && (reg_addr == OFF_STATUS);
    assign busy_c      = (state_q != ST_IDLE);
    assign cmd_idx_c   = reg_wdata[CMD_IDX_LSB +: AW];
    assign status_c    = DW'({verify_err_c, timeout_q, done_q, busy_c});
    assign in_wait_c   = (state_q == ST_WR_WAIT) || (state_q == ST_RD_WAIT);
    assign load_c      = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);

    lpm_ack_timer #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk       (AXI_ACLK),
        .rst_n     (AXI_RESETN),
        .load      (load_c),
        .dec       (in_wait_c),
        .expired_c (expired_c)
    );

    always_comb begin
        state_d     = state_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        reg_rdata_d = reg_rdata_q;
        wr_req_d    = 1'b0;
        rd_req_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
`ifdef LPM_TBL_VERIFY_EN
        verify_err_d = verify_err_q;
        vfy_d        = vfy_q;
`endif

        if (reg_wr_en && in_bank(reg_addr, OFF_WDATA0)) begin
            wdata_d[reg_addr[3:2]] = reg_wdata;
        end

        if (reg_rd_en) begin
            if (reg_addr == OFF_STATUS) begin
                reg_rdata_d = status_c;
            end else if (in_bank(reg_addr, OFF_WDATA0)) begin
                reg_rdata_d = wdata_q[reg_addr[3:2]];
            end else if (in_bank(reg_addr, OFF_RDATA0)) begin
                reg_rdata_d = rdata_q[reg_addr[3:2]];
            end else begin
                reg_rdata_d = '0;
            end
        end

        // Clear-on-read first so that an event in the same cycle still sticks
        if (status_rd_c) begin
            done_d    = 1'b0;
            timeout_d = 1'b0;
`ifdef LPM_TBL_VERIFY_EN
            verify_err_d = 1'b0;
`endif
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_wr_c && reg_wdata[CMD_WR_BIT]) begin
                    state_d   = ST_WR_REQ;
                    wr_req_d  = 1'b1;
                    wr_addr_d = cmd_idx_c;
                    wr_data_d = wdata_q;
`ifdef LPM_TBL_VERIFY_EN
                    vfy_d     = 1'b0;
`endif
                end else if (cmd_wr_c && reg_wdata[CMD_RD_BIT]) begin
                    state_d   = ST_RD_REQ;
                    rd_req_d  = 1'b1;
                    rd_addr_d = cmd_idx_c;
`ifdef LPM_TBL_VERIFY_EN
                    vfy_d     = 1'b0;
`endif
                end
            end
            ST_WR_REQ: begin
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (tbl_wr_ack) begin
`ifdef LPM_TBL_VERIFY_EN
                    state_d   = ST_RD_REQ;
                    rd_req_d  = 1'b1;
                    rd_addr_d = wr_addr_q;
                    vfy_d     = 1'b1;
`else
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
`endif
                end else if (expired_c) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
            end
            ST_RD_REQ: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (tbl_rd_ack) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    rdata_d = tbl_rd_data;
`ifdef LPM_TBL_VERIFY_EN
                    if (vfy_q && (tbl_rd_data != wr_data_q)) begin
                        verify_err_d = 1'b1;
                    end
                    vfy_d = 1'b0;
`endif
                end else if (expired_c) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
`ifdef LPM_TBL_VERIFY_EN
                    vfy_d     = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            state_q     <= ST_IDLE;
            wdata_q     <= '0;
            rdata_q     <= '0;
            reg_rdata_q <= '0;
            wr_req_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef LPM_TBL_VERIFY_EN
            verify_err_q <= 1'b0;
            vfy_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            reg_rdata_q <= reg_rdata_d;
            wr_req_q    <= wr_req_d;
            rd_req_q    <= rd_req_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
`ifdef LPM_TBL_VERIFY_EN
            verify_err_q <= verify_err_d;
            vfy_q        <= vfy_d;
`endif
        end
    end

    assign reg_rdata   = reg_rdata_q;
    assign tbl_wr_req  = wr_req_q;
    assign tbl_rd_req  = rd_req_q;
    assign tbl_wr_addr = wr_addr_q;
    assign tbl_rd_addr = rd_addr_q;
    assign tbl_wr_data = wr_data_q;

endmodule

// File: tb/tb_lpm_tbl_access_ctrl.sv
// Directed plus randomized bench for lpm_tbl_access_ctrl against a transaction-level model.
module tb_lpm_tbl_access_ctrl;
    import lpm_tbl_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int          TMO   = 16;
    localparam int          NOACK = 1000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            reg_wr_en = 1'b0;
    logic            reg_rd_en = 1'b0;
    logic [5:0]      reg_addr = '0;
    logic [DW-1:0]   reg_wdata = '0;
    logic [DW-1:0]   reg_rdata;
    logic            tbl_wr_req, tbl_rd_req;
    logic [AW-1:0]   tbl_wr_addr, tbl_rd_addr;
    logic [127:0]    tbl_wr_data;
    logic [127:0]    tbl_rd_data = '0;
    logic            tbl_wr_ack = 1'b0;
    logic            tbl_rd_ack = 1'b0;

    lpm_tbl_access_ctrl #(
        .C_S_AXI_DATA_WIDTH (DW),
        .TBL_ADDR_WIDTH     (AW),
        .ACK_TIMEOUT        (TMO)
    ) dut (
        .AXI_ACLK    (clk),
        .AXI_RESETN  (rst_n),
        .reg_wr_en   (reg_wr_en),
        .reg_rd_en   (reg_rd_en),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .tbl_wr_req  (tbl_wr_req),
        .tbl_rd_req  (tbl_rd_req),
        .tbl_wr_addr (tbl_wr_addr),
        .tbl_rd_addr (tbl_rd_addr),
        .tbl_wr_data (tbl_wr_data),
        .tbl_rd_data (tbl_rd_data),
        .tbl_wr_ack  (tbl_wr_ack),
        .tbl_rd_ack  (tbl_rd_ack)
    );

    always #5 clk = ~clk;

    // Request pulse monitor: counts high cycles and records what each pulse carried
    int           wr_pulses = 0;
    int           rd_pulses = 0;
    logic [AW-1:0] mon_wr_addr = '0;
    logic [AW-1:0] mon_rd_addr = '0;
    logic [127:0]  mon_wr_data = '0;
    always @(posedge clk) begin
        if (tbl_wr_req) begin
            wr_pulses   <= wr_pulses + 1;
            mon_wr_addr <= tbl_wr_addr;
            mon_wr_data <= tbl_wr_data;
        end
        if (tbl_rd_req) begin
            rd_pulses   <= rd_pulses + 1;
            mon_rd_addr <= tbl_rd_addr;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [3:0][31:0] m_wdata = '0;
    logic [3:0][31:0] m_rdata = '0;
    bit               m_done = 1'b0, m_tmo = 1'b0, m_verr = 1'b0;
    int               e_wr_pulses = 0, e_rd_pulses = 0;
    logic [AW-1:0]    e_wr_addr = '0, e_rd_addr = '0;
    logic [127:0]     e_wr_data = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [5:0] a, input logic [31:0] d);
        reg_wr_en = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        tick();
        reg_wr_en = 1'b0;
        if (a >= 6'h10 && a <= 6'h1C && a[1:0] == 2'b00) m_wdata[a[3:2]] = d;
    endtask

    task automatic rd_reg(input logic [5:0] a, output logic [31:0] d);
        reg_rd_en = 1'b1;
        reg_addr  = a;
        tick();
        reg_rd_en = 1'b0;
        d = reg_rdata;
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d;
        logic [31:0] exp;
        exp = 32'({m_verr, m_tmo, m_done, 1'b0});
        rd_reg(OFF_STATUS, d);
        check(tag, d, exp);
        m_done = 1'b0;
        m_tmo  = 1'b0;
        m_verr = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] d;
        for (int w = 0; w < 4; w++) begin
            rd_reg(6'(32'h20 + 4 * w), d);
            check({tag, "_rdata"}, d, m_rdata[w]);
        end
        check({tag, "_wr_pulses"}, wr_pulses, e_wr_pulses);
        check({tag, "_rd_pulses"}, rd_pulses, e_rd_pulses);
        check({tag, "_wr_addr_out"}, tbl_wr_addr, e_wr_addr);
        check({tag, "_wr_data_out"}, tbl_wr_data, e_wr_data);
    endtask

    // One command with an ack k cycles after the request cycle (k=0: during the request)
    task automatic txn(input string tag, input logic [1:0] bits, input int idx, input int k,
                       input int op, input bit flip_en, input logic [127:0] rd_val);
        logic [127:0] flip;
        bit is_wr, acc;
        is_wr = bits[0];
        acc   = (k >= 1) && (k <= TMO);
        flip  = '0;
        if (flip_en) flip[96] = 1'b1;
        if (is_wr) begin
            e_wr_pulses++;
            e_wr_addr = AW'(idx);
            e_wr_data = m_wdata;
`ifdef LPM_TBL_VERIFY_EN
            if (acc) begin
                e_rd_pulses++;
                e_rd_addr = AW'(idx);
            end
`endif
        end else begin
            e_rd_pulses++;
            e_rd_addr = AW'(idx);
        end
        wr_reg(OFF_CMD, 32'(bits) | (32'(idx) << 8));
        check({tag, "_wr_req_latency"}, tbl_wr_req, is_wr);
        check({tag, "_rd_req_latency"}, tbl_rd_req, !is_wr);
        for (int c = 0; c <= TMO + 6; c++) begin
            tbl_rd_data = {$urandom, $urandom, $urandom, $urandom};
            if (c == k) begin
                if (is_wr) begin
                    tbl_wr_ack = 1'b1;
                end else begin
                    tbl_rd_ack  = 1'b1;
                    tbl_rd_data = rd_val;
                    if (acc) m_rdata = rd_val;
                end
            end
`ifdef LPM_TBL_VERIFY_EN
            if (is_wr && acc && c == k + 1) check({tag, "_verify_rd_req"}, tbl_rd_req, 1'b1);
            if (is_wr && acc && c == k + 2) begin
                tbl_rd_ack  = 1'b1;
                tbl_rd_data = e_wr_data ^ flip;
                m_rdata     = e_wr_data ^ flip;
            end
`endif
            if (c == 1 && k != 1 && op == 1) begin
                reg_wr_en = 1'b1;
                reg_addr  = OFF_CMD;
                reg_wdata = 32'($urandom_range(1, 3)) | (32'($urandom_range(0, 31)) << 8);
            end else if (c == 1 && k != 1 && op == 2) begin
                reg_wr_en = 1'b1;
                reg_addr  = 6'(32'h10 + 4 * $urandom_range(0, 3));
                reg_wdata = $urandom;
                m_wdata[reg_addr[3:2]] = reg_wdata;
            end else if (c == 1 && k != 1 && op == 3) begin
                reg_rd_en = 1'b1;
                reg_addr  = OFF_STATUS;
            end
            tick();
            if (c == 1 && k != 1 && op == 3) check({tag, "_busy_status"}, reg_rdata, 32'h1);
            tbl_wr_ack = 1'b0;
            tbl_rd_ack = 1'b0;
            reg_wr_en  = 1'b0;
            reg_rd_en  = 1'b0;
        end
        if (acc) begin
            m_done = 1'b1;
`ifdef LPM_TBL_VERIFY_EN
            if (is_wr) m_verr = flip_en;
`endif
        end else begin
            m_tmo = 1'b1;
        end
        check_status({tag, "_status"});
        check_status({tag, "_status_cleared"});
        check_regs(tag);
        if (is_wr) begin
            check({tag, "_pulse_addr"}, mon_wr_addr, e_wr_addr);
            check({tag, "_pulse_data"}, mon_wr_data, e_wr_data);
        end
        if (!is_wr || acc) begin
            if (e_rd_pulses == rd_pulses && (!is_wr || e_rd_addr == AW'(idx)))
                check({tag, "_rd_pulse_addr"}, mon_rd_addr, e_rd_addr);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [5:0]  unmapped [5];
        unmapped = '{6'h00, 6'h08, 6'h12, 6'h30, 6'h3C};

        #2;
        check("reset_rdata", reg_rdata, 32'h0);
        check("reset_wr_req", tbl_wr_req, 1'b0);
        check("reset_wr_data", tbl_wr_data, 128'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check_status("reset_status");

        for (int i = 0; i < 5; i++) begin
            rd_reg(unmapped[i], d);
            check("unmapped_read", d, 32'h0);
        end

        wr_reg(6'h10, 32'h0A000000);
        wr_reg(6'h14, 32'hFFFFFF00);
        wr_reg(6'h18, 32'h0A000001);
        wr_reg(6'h1C, 32'h00000001);
        rd_reg(6'h18, d);
        check("wdata2_readback", d, 32'h0A000001);
        txn("wr_idx3", 2'b01, 3, 2, 0, 1'b0, '0);
        check("wr_idx3_entry", e_wr_data, 128'h00000001_0A000001_FFFFFF00_0A000000);

        txn("rd_idx7", 2'b10, 7, 1, 0, 1'b0, {96'h11111111_22222222_33333333, 32'hDEADBEEF});
        check("rd_idx7_rdata0", m_rdata[0], 32'hDEADBEEF);

        txn("rd_noack", 2'b10, 5, NOACK, 3, 1'b0, '0);
        txn("cmd_busy", 2'b01, 12, 5, 1, 1'b0, '0);

        tbl_wr_ack = 1'b1;
        tbl_rd_ack = 1'b1;
        tick();
        tbl_wr_ack = 1'b0;
        tbl_rd_ack = 1'b0;
        tick();
        check_status("stray_ack_status");
        check_regs("stray_ack");

        txn("both_bits", 2'b11, 20, 3, 2, 1'b0, '0);
        txn("ack_in_req", 2'b10, 1, 0, 0, 1'b0, {$urandom, $urandom, $urandom, $urandom});
        txn("ack_at_limit", 2'b01, 30, TMO, 0, 1'b0, '0);
        txn("ack_past_limit", 2'b10, 31, TMO + 1, 0, 1'b0, {$urandom, $urandom, $urandom, $urandom});

`ifdef LPM_TBL_VERIFY_EN
        txn("verify_bit96", 2'b01, 4, 2, 0, 1'b1, '0);
`endif

        // Reset in WR_WAIT, then a late ack
        wr_reg(6'h10, 32'hCAFEF00D);
        wr_reg(OFF_CMD, 32'h00000901);
        e_wr_pulses++;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_wr_data", tbl_wr_data, 128'h0);
        check("midreset_wr_addr", tbl_wr_addr, 5'h0);
        check("midreset_rdata", reg_rdata, 32'h0);
        m_wdata = '0;
        m_rdata = '0;
        m_done = 1'b0;
        m_tmo = 1'b0;
        m_verr = 1'b0;
        e_wr_addr = '0;
        e_wr_data = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tbl_wr_ack = 1'b1;
        tick();
        tbl_wr_ack = 1'b0;
        tick();
        check_status("midreset_status");
        rd_reg(6'h10, d);
        check("midreset_wdata0", d, 32'h0);
        check_regs("midreset");

        for (int n = 0; n < 16; n++) begin
            int k;
            for (int w = 0; w < 4; w++) begin
                if ($urandom_range(0, 1) == 1) wr_reg(6'(32'h10 + 4 * w), $urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                tbl_wr_ack = 1'b1;
                tbl_rd_ack = 1'b1;
                tick();
                tbl_wr_ack = 1'b0;
                tbl_rd_ack = 1'b0;
            end
            k = ($urandom_range(0, 4) == 0) ? NOACK : int'($urandom_range(0, TMO + 2));
            txn("rand", 2'($urandom_range(1, 3)), int'($urandom_range(0, 31)), k,
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                {$urandom, $urandom, $urandom, $urandom});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

endmodule
